// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, FSM states, round-index type and
// the byte-level round helpers (S-box, ShiftRows, MixColumns column).
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_RW = 4;
    localparam int BLK_W  = 128;

    typedef logic [AES_RW-1:0]  round_t;
    typedef logic [BLK_W-1:0]   block_t;
    // Byte 0 (FIPS-197 order) is element 0, i.e. bits [127:120].
    typedef logic [0:15][7:0]   bytes_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of the column-major state rotates left by r columns.
    function automatic bytes_t shift_rows(input bytes_t b);
        return {b[0],  b[5],  b[10], b[15],
                b[4],  b[9],  b[14], b[3],
                b[8],  b[13], b[2],  b[7],
                b[12], b[1],  b[6],  b[11]};
    endfunction

    // One state column times the fixed MixColumns matrix.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / block-out handshake plus round-key fetch bus of the AES round controller.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    block_t in_data;
    logic   key_valid;
    round_t key_idx;
    block_t round_key;
    logic   out_valid;
    logic   out_ready;
    block_t out_data;
    logic   busy;
    round_t round;

    // Host and key store side.
    modport master (
        output in_valid, in_data, key_valid, round_key, out_ready,
        input  in_ready, key_idx, out_valid, out_data, busy, round
    );

    // Controller side.
    modport slave (
        input  in_valid, in_data, key_valid, round_key, out_ready,
        output in_ready, key_idx, out_valid, out_data, busy, round
    );

endinterface

// File: rtl/aes_round.sv
// Combinational AES round: SubBytes -> ShiftRows -> MixColumns (skipped on
// the final round) -> AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  block_t state_in,
    input  block_t round_key,
    input  logic   last,
    output block_t state_out
);

    bytes_t in_s;
    bytes_t sb_s;
    bytes_t sr_s;
    bytes_t mc_s;
    block_t mix_s;

    assign in_s = state_in;

    for (genvar i = 0; i < 16; i++) begin : g_sb
        assign sb_s[i] = sbox(in_s[i]);
    end

    assign sr_s = shift_rows(sb_s);

    for (genvar c = 0; c < 4; c++) begin : g_mc
        assign mc_s[4*c +: 4] = mix_column(sr_s[4*c +: 4]);
    end

    // Select MixColumns output or bypass, then add the round key.
    always_comb begin
        mix_s     = mc_s;
        state_out = {BLK_W{1'b0}};
        if (last) begin
            mix_s = sr_s;
        end else begin
            mix_s = mc_s;
        end
        state_out = mix_s ^ round_key;
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: one round per clock over a shared
// round datapath, round keys fetched by index from an external schedule store.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
)(
    input  logic             clk,
    input  logic             rst_n,
    aes_round_ctrl_if.slave  bus
);

    localparam round_t NR_R = round_t'(NR);

    aes_state_e fsm_r;
    round_t     round_r;
    block_t     blk_r;
    logic       out_valid_r;
    logic       busy_r;

    logic       in_ready_s;
    logic       accept_s;
    logic       last_s;
    round_t     key_idx_s;
    block_t     round_out_s;

    // Acceptance readiness and key index depend only on state and key_valid.
    always_comb begin
        in_ready_s = 1'b0;
        key_idx_s  = {AES_RW{1'b0}};
        if (fsm_r == IDLE) begin
            in_ready_s = bus.key_valid;
        end else begin
            in_ready_s = 1'b0;
        end
        if (fsm_r == RUN) begin
            key_idx_s = round_r;
        end else begin
            key_idx_s = {AES_RW{1'b0}};
        end
    end

    assign accept_s = bus.in_valid && in_ready_s;
    assign last_s   = (round_r == NR_R);

    aes_round u_round (
        .state_in  (blk_r),
        .round_key (bus.round_key),
        .last      (last_s),
        .state_out (round_out_s)
    );

    // Controller FSM, round counter, state register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_r       <= IDLE;
            round_r     <= {AES_RW{1'b0}};
            blk_r       <= {BLK_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (accept_s) begin
                        blk_r   <= bus.in_data ^ bus.round_key;
                        round_r <= round_t'(1);
                        busy_r  <= 1'b1;
                        fsm_r   <= RUN;
                    end
                end
                RUN: begin
                    blk_r <= round_out_s;
                    if (last_s) begin
                        out_valid_r <= 1'b1;
                        fsm_r       <= DONE;
                    end else begin
                        round_r <= round_r + round_t'(1);
                    end
                end
                DONE: begin
                    // The result stays in blk_r; only the handshake state clears.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        round_r     <= {AES_RW{1'b0}};
                        fsm_r       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    round_r     <= {AES_RW{1'b0}};
                    fsm_r       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.key_idx   = key_idx_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = blk_r;
    assign bus.busy      = busy_r;
    assign bus.round     = round_r;

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption controller. It accepts one 128-bit plaintext block over a valid/ready handshake and applies the initial AddRoundKey, nine full rounds and one final round, one round per clock. The round-function modules (SubBytes, ShiftRows, MixColumns, AddRoundKey) are reused on every round, and the controller fetches round keys by index from an external key-schedule store. It sits between the host block interface and the key expansion unit, and is the only sequencer of the shared round datapath.

## Interface
- `NR`, 10, number of rounds; the final round omits MixColumns.
- `RW`, 4, round counter / key index width; must satisfy 2^RW > NR.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: plaintext offered.
- `in_ready` output 1: block can be accepted.
- `in_data` input 128: plaintext, FIPS-197 byte 0 in bits [127:120], column-major.
- `key_valid` input 1: key store holds a complete expanded schedule.
- `key_idx` output RW: round-key index requested this cycle.
- `round_key` input 128: round key for `key_idx`, combinational, same cycle.
- `out_valid` output 1: ciphertext available.
- `out_ready` input 1: consumer accepts ciphertext.
- `out_data` output 128: ciphertext, same byte order as `in_data`.
- `busy` output 1: high in RUN and DONE.
- `round` output RW: current round counter, for debug.

## Operation
- States:
  - IDLE: waiting for a block.
  - RUN: applying rounds 1..NR.
  - DONE: holding the result.
- `in_ready` = (state==IDLE) && `key_valid`. Acceptance occurs when `in_valid` && `in_ready`.
- In IDLE, `key_idx` = 0. On acceptance:
  - `state_q` <= `in_data` ^ `round_key` (round 0).
  - `round` <= 1.
  - next state RUN.
- In RUN, `key_idx` = `round`.
  - If `round` < NR: `state_q` <= ARK(MC(SR(SB(`state_q`))), `round_key`) and `round` increments.
  - If `round` == NR: `state_q` <= ARK(SR(SB(`state_q`)), `round_key`), next state DONE, `round` holds at NR.
- In DONE:
  - `out_valid` = 1 and `out_data` = `state_q`.
  - On `out_ready`, go to IDLE and clear `round` to 0.
  - `state_q` is not cleared; `out_data` is don't-care once `out_valid` is low.
- `key_valid` is sampled only at acceptance. Its deassertion during RUN is ignored, and the key store must hold its contents until DONE.
- `in_valid` is ignored outside IDLE. A new block cannot be accepted in the same cycle as an output handshake.
- The round counter never wraps; values above NR are unreachable.

## Timing
- Reset (`rst_n` low at a rising edge):
  - state = IDLE, `round` = 0, `state_q` = 0.
  - `out_valid` = 0, `busy` = 0, `key_idx` = 0.
  - `in_ready` follows `key_valid`.
- Reset mid-RUN or mid-DONE aborts the block; no output is produced.
- Latency: with acceptance at edge k, `out_valid` rises after edge k+NR (10 cycles for AES-128).
- Throughput: one block per NR+2 cycles at best (acceptance cycle, NR rounds, output handshake).
- `out_valid` and `out_data` are registered and stable until the handshake.
- `in_ready` and `key_idx` are combinational from state and `key_valid`; there is no combinational path from `in_valid` or `out_ready` to any output.
- The key store must return `round_key` in the same cycle as `key_idx`. The critical path is `round_key` -> ARK -> `state_q`, in series with SB/SR/MC.

## Structure
- Shared package `aes_pkg`:
  - state enum (IDLE, RUN, DONE).
  - `AES_NR` = 10.
  - block width 128.
  - round-index type.
- One natural sub-module, `aes_round`: combinational SubBytes -> ShiftRows -> MixColumns (bypassed when input `last`=1) -> AddRoundKey, built from the existing ShiftRows and AddRoundKey modules.
- The controller holds the FSM, the round counter and the state register.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> `out_data` 3925841d02dc09fbdc118597196a0b32, `out_valid` exactly 10 cycles after acceptance.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a; `key_idx` sequence 0,1,...,10 observed.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE -> `out_valid` and `out_data` stable, `in_ready`=0, `in_valid` pulses ignored; release -> IDLE next cycle.
- `key_valid`=0 with `in_valid`=1 -> `in_ready`=0, no acceptance. Raise `key_valid` -> acceptance that cycle.
- Assert `rst_n`=0 at round 5 -> next cycle IDLE, `round`=0, `out_valid`=0. A following App. B block still yields the correct ciphertext.
- Back-to-back: both vectors in sequence with `out_ready` tied to 1 -> both ciphertexts correct, 12-cycle spacing between acceptances.
